// File: rtl/dct_frame_sequencer.sv
// Frame sequencer for the 16-point DCT core: gathers 16 samples, feeds mirrored
// pairs, captures indexed coefficient pairs and replays them in index order.
module dct_frame_sequencer #(
  parameter int DATA_W  = 8,
  parameter int COEF_W  = 24,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              dct_start,
  output logic [DATA_W-1:0] dct_in_a,
  output logic [DATA_W-1:0] dct_in_b,
  input  logic [COEF_W-1:0] dct_out_a,
  input  logic [COEF_W-1:0] dct_out_b,
  input  logic [3:0]        dct_index_a,
  input  logic [3:0]        dct_index_b,
  input  logic              dct_output_en,
  output logic              coef_valid,
  input  logic              coef_ready,
  output logic [COEF_W-1:0] coef_data,
  output logic [3:0]        coef_index,
  output logic              coef_last,
  output logic              busy,
  output logic              err_timeout
);

  localparam int WD_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {LOAD, FEED, WAIT, CAPTURE, DRAIN} state_t;

  state_t            state;
  logic [3:0]        cnt;
  logic [3:0]        k;
  logic [2:0]        pcnt;
  logic [WD_W-1:0]   wd;
  logic [DATA_W-1:0] sbuf [16];
  logic [COEF_W-1:0] res  [16];
  logic              accept;
  logic              cap;
  logic [COEF_W-1:0] res0_nxt;

  assign accept = (state == LOAD) && in_valid && in_ready;
  assign cap    = ((state == WAIT) || (state == CAPTURE)) && dct_output_en;

  // res[0] as it will be after this cycle's capture, so the first coefficient
  // can be presented on the edge that completes the last pair.
  always_comb begin
    res0_nxt = res[0];
    if (cap && dct_index_a == 4'd0) res0_nxt = dct_out_a;
    if (cap && dct_index_b == 4'd0) res0_nxt = dct_out_b;
  end

  // Storage needs no reset; B is written last so it wins on an index collision.
  always_ff @(posedge clk) begin
    if (accept) sbuf[cnt] <= in_data;
    if (cap) begin
      res[dct_index_a] <= dct_out_a;
      res[dct_index_b] <= dct_out_b;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= LOAD;
      cnt         <= '0;
      k           <= '0;
      pcnt        <= '0;
      wd          <= '0;
      in_ready    <= 1'b1;
      dct_start   <= 1'b0;
      dct_in_a    <= '0;
      dct_in_b    <= '0;
      coef_valid  <= 1'b0;
      coef_data   <= '0;
      coef_index  <= '0;
      coef_last   <= 1'b0;
      busy        <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      dct_start <= 1'b0;
      case (state)
        LOAD: begin
          if (accept) begin
            cnt <= cnt + 4'd1;
            if (cnt == 4'd15) begin
              // Sample 15 is still in flight to sbuf, so take it straight from the bus.
              state     <= FEED;
              in_ready  <= 1'b0;
              busy      <= 1'b1;
              dct_start <= 1'b1;
              dct_in_a  <= sbuf[0];
              dct_in_b  <= in_data;
              k         <= '0;
              cnt       <= '0;
            end
          end
        end
        FEED: begin
          if (k == 4'd7) begin
            dct_in_a <= '0;
            dct_in_b <= '0;
            state    <= WAIT;
            wd       <= '0;
            pcnt     <= '0;
          end else begin
            dct_in_a <= sbuf[k + 4'd1];
            dct_in_b <= sbuf[4'd14 - k];
            k        <= k + 4'd1;
          end
        end
        WAIT, CAPTURE: begin
          if (dct_output_en) begin
            wd    <= '0;
            pcnt  <= pcnt + 3'd1;
            state <= CAPTURE;
            if (pcnt == 3'd7) begin
              state      <= DRAIN;
              coef_valid <= 1'b1;
              coef_index <= '0;
              coef_data  <= res0_nxt;
              coef_last  <= 1'b0;
            end
          end else if (wd == WD_W'(TIMEOUT - 1)) begin
            err_timeout <= 1'b1;
            state       <= LOAD;
            in_ready    <= 1'b1;
            busy        <= 1'b0;
            cnt         <= '0;
          end else begin
            wd <= wd + 1'b1;
          end
        end
        DRAIN: begin
          if (coef_ready) begin
            if (coef_index == 4'd15) begin
              coef_valid <= 1'b0;
              coef_last  <= 1'b0;
              coef_index <= '0;
              coef_data  <= '0;
              state      <= LOAD;
              in_ready   <= 1'b1;
              busy       <= 1'b0;
              cnt        <= '0;
            end else begin
              coef_index <= coef_index + 4'd1;
              coef_data  <= res[coef_index + 4'd1];
              coef_last  <= (coef_index == 4'd14);
            end
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule

// File: doc/dct_frame_sequencer.md
Name: dct_frame_sequencer

Overview:
Controller that sequences the 16-point DCT core. It collects 16 8-bit samples from an upstream valid/ready stream into a frame buffer, then feeds the core the mirrored pairs (x[i], x[15-i]) for 8 consecutive cycles, starting with a one-cycle start pulse. It captures the core's indexed coefficient pairs into a result buffer and replays them downstream in ascending index order over a valid/ready stream. A watchdog flags a core that never asserts output_en.

Parameters:
DATA_W, 8, sample width (matches core INPUT_A/INPUT_B)
COEF_W, 24, coefficient width, signed Q.8 (matches core OUTPUT_A/OUTPUT_B)
TIMEOUT, 64, max cycles from end of FEED to first dct_output_en before error

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
in_valid  in  1  upstream sample valid
in_ready  out  1  sequencer accepts a sample this cycle
in_data  in  DATA_W  unsigned sample
dct_start  out  1  one-cycle start pulse to core, coincident with first pair
dct_in_a  out  DATA_W  core INPUT_A
dct_in_b  out  DATA_W  core INPUT_B
dct_out_a  in  COEF_W  core OUTPUT_A, signed
dct_out_b  in  COEF_W  core OUTPUT_B, signed
dct_index_a  in  4  core INDEX_A
dct_index_b  in  4  core INDEX_B
dct_output_en  in  1  core result-pair valid
coef_valid  out  1  downstream coefficient valid
coef_ready  in  1  downstream accept
coef_data  out  COEF_W  coefficient X[coef_index], signed
coef_index  out  4  coefficient index 0..15
coef_last  out  1  high with coef_index==15
busy  out  1  high in every state except LOAD
err_timeout  out  1  sticky watchdog error, cleared only by reset

Behaviour:
- Reset: state=LOAD; sample count=0; in_ready=1; dct_start=0; dct_in_a=0; dct_in_b=0; coef_valid=0; coef_data=0; coef_index=0; coef_last=0; busy=0; err_timeout=0. Buffer contents are don't-care.
- Reset is synchronous and overrides all states. A reset mid-FEED or mid-CAPTURE abandons the frame. The core is reset by the same reset.
- All core-facing and downstream outputs are registered.

LOAD:
- in_ready=1.
- On each in_valid&&in_ready, write in_data to buf[cnt] and increment cnt.
- On the 16th accept (cnt==15), the next state is FEED and in_ready drops the following cycle.

FEED (8 cycles, k=0..7):
- Drive dct_in_a=buf[k] and dct_in_b=buf[15-k].
- dct_start=1 only at k=0.
- The pairs are back-to-back with no gaps; upstream cannot stall them.
- After k=7, dct_in_a and dct_in_b return to 0 and the state moves to WAIT.

WAIT:
- The watchdog counts cycles.
- If dct_output_en is seen, go to CAPTURE and capture that same cycle.
- If TIMEOUT cycles elapse with no output_en, set err_timeout=1 and go to LOAD with cnt=0. The frame is dropped.

CAPTURE:
- Every cycle with dct_output_en=1: res[dct_index_a]<=dct_out_a and res[dct_index_b]<=dct_out_b. Increment pair count.
- After 8 pairs, go to DRAIN.
- If output_en drops before 8 pairs, keep waiting. The watchdog restarts and applies as in WAIT.
- If dct_index_a==dct_index_b, the B write wins.

DRAIN:
- Present res[0..15] in index order with coef_valid=1.
- Advance on coef_valid&&coef_ready; hold data stable while ready is low.
- coef_last=1 with index 15.
- After the index-15 handshake, coef_valid=0 the next cycle and the state returns to LOAD.
- in_ready stays 0 during DRAIN; there is no frame overlap.

Other rules:
- dct_output_en outside WAIT/CAPTURE is ignored.
- Latency: the first coefficient appears 1 cycle after the last capture.

Test Plan:
- Frame and pairing: send samples 1,3,5,7,9,17,19,21,22,18,18,16,8,6,4,2 with in_valid held high. Required: in_ready=0 after the 16th sample. dct_start is high for exactly 1 cycle with (a,b)=(1,2). The following pairs are (3,4),(5,6),(7,8),(9,16),(17,18),(19,18),(21,22) on consecutive cycles, then 0/0.
- Reorder and capture: use a core stub that returns pairs on output_en in index order 0/1, 2/3 ... with OUTPUT=index*256. Required: coef_data=index*256 for coef_index 0..15 in order, and coef_last only at 15.
- Backpressure: toggle coef_ready 1,0,0,1 repeatedly during DRAIN. Required: coef_data and coef_index hold while ready=0. Exactly 16 handshakes occur, and the next frame is then accepted.
- Watchdog: stub never asserts output_en. Required: err_timeout=1 exactly TIMEOUT cycles after FEED ends, the state returns to LOAD with in_ready=1, and err_timeout stays set.
- Reset mid-operation: assert reset at FEED k=3. Required: on the next edge all outputs equal reset values. A subsequent full frame processes correctly with err_timeout=0.
- Gapped input and signed data: in_valid with random gaps, and a stub returning negative coefficients (-1.5 = 0xFFFE80). Required: the sample order is preserved and negative values pass through bit-exact.
